alpha_trim_mean: RTL

Computes the modified alpha-trimmed mean of one DN-sample filter window. It sits directly downstream of `parallel_sort` in the Modified Alpha Mean Filter datapath. On each sort completion it discards the TRIM smallest and TRIM largest samples by rank, then accumulates the remaining KEEP samples one per cycle. It divides the sum by KEEP with round-half-up and emits one DW-bit filtered pixel.

---
 rtl/alpha_mean_pkg.sv | 21 ++
 rtl/seq_divider.sv | 57 +++++
 rtl/alpha_trim_mean.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alpha_mean_pkg.sv
// Shared definitions for the modified alpha-trimmed mean datapath:
// one-hot FSM encoding and width helper functions.
package alpha_mean_pkg;

    typedef enum logic [4:0] {
        StIdle    = 5'b00001,
        StCapture = 5'b00010,
        StAccum   = 5'b00100,
        StDivide  = 5'b01000,
        StDone    = 5'b10000
    } state_e;

    function automatic int unsigned keep_f(input int unsigned dn, input int unsigned trim);
        return dn - 2 * trim;
    endfunction

    function automatic int unsigned sumw_f(input int unsigned dw, input int unsigned keep);
        return dw + $clog2(keep + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider by a constant: one quotient bit per cycle, MSB first,
// W cycles after a start pulse.
module seq_divider #(
    parameter int unsigned W       = 12,
    parameter int unsigned Divisor = 15,
    parameter int unsigned OutW    = W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    dividend,
    output logic [OutW-1:0] quotient,
    output logic            done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_shift;
    logic          ge;

    always_comb begin
        rem_shift = {rem_q, quo_q[W-1]};
        ge        = rem_shift >= (W + 1)'(Divisor);
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = CW'(W);
        end else if (cnt_q != '0) begin
            rem_d = W'(ge ? rem_shift - (W + 1)'(Divisor) : rem_shift);
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Quotient is the result of the step in progress, so it is final while done is high.
    assign quotient = OutW'({quo_q[W-2:0], ge});
    assign done     = (cnt_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alpha_trim_mean.sv
// Modified alpha-trimmed mean of one sorted window: drop TRIM samples at each end by rank,
// sum the rest one per cycle, then divide by KEEP with round-half-up.
module alpha_trim_mean
    import alpha_mean_pkg::*;
#(
    parameter int unsigned DN          = 25,
    parameter int unsigned DW          = 8,
    parameter int unsigned DW_sequence = $clog2(DN),
    parameter int unsigned TRIM        = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sort_finish,
    input  logic [DW*DN-1:0]          data_window,
    input  logic [DW_sequence*DN-1:0] sequence_sorted,
    output logic [DW-1:0]             mean_out,
    output logic                      mean_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned KEEP = keep_f(DN, TRIM);
    localparam int unsigned SUMW = sumw_f(DW, KEEP);
    localparam logic [DW_sequence-1:0] KFirst = DW_sequence'(TRIM);
    localparam logic [DW_sequence-1:0] KLast  = DW_sequence'(DN - TRIM - 1);

    state_e                      state_q, state_d;
    logic [DW*DN-1:0]            data_q, data_d;
    logic [DW_sequence*DN-1:0]   seq_q, seq_d;
    logic [SUMW-1:0]             sum_q, sum_d;
    logic [DW_sequence-1:0]      k_q, k_d;
    logic [DW-1:0]               mean_out_q, mean_out_d;
    logic                        mean_valid_q, mean_valid_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;

    logic [DW_sequence-1:0]      rank_idx;
    logic [DW-1:0]               sample;
    logic                        div_start;
    logic                        div_done;
    logic [SUMW-1:0]             div_dividend;
    logic [DW-1:0]               div_quotient;

    // Rank k -> original index -> sample; an index >= DN selects zero.
    always_comb begin
        rank_idx = '0;
        for (int i = 0; i < DN; i++) begin
            if (k_q == DW_sequence'(i)) rank_idx = seq_q[i*DW_sequence +: DW_sequence];
        end
        sample = '0;
        for (int i = 0; i < DN; i++) begin
            if (rank_idx == DW_sequence'(i)) sample = data_q[i*DW +: DW];
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        seq_d      = seq_q;
        sum_d      = sum_q;
        k_d        = k_q;
        mean_out_d = mean_out_q;
        div_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sort_finish) state_d = StCapture;
            end
            StCapture: begin
                data_d  = data_window;
                seq_d   = sequence_sorted;
                sum_d   = '0;
                k_d     = KFirst;
                state_d = StAccum;
            end
            StAccum: begin
                sum_d = sum_q + SUMW'(sample);
                k_d   = k_q + DW_sequence'(1);
                if (k_q == KLast) begin
                    div_start = 1'b1;
                    state_d   = StDivide;
                end
            end
            StDivide: begin
                if (div_done) begin
                    mean_out_d = div_quotient;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        mean_valid_d = (state_d == StDone);
        busy_d       = (state_d != StIdle);
        overrun_d    = sort_finish && (state_q != StIdle);
    end

    // Divider loads the final sum on the edge that leaves ACCUM.
    assign div_dividend = sum_d + SUMW'(KEEP / 2);

    seq_divider #(
        .W      (SUMW),
        .Divisor(KEEP),
        .OutW   (DW)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(div_dividend),
        .quotient(div_quotient),
        .done    (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            data_q       <= '0;
            seq_q        <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            mean_out_q   <= '0;
            mean_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            seq_q        <= seq_d;
            sum_q        <= sum_d;
            k_q          <= k_d;
            mean_out_q   <= mean_out_d;
            mean_valid_q <= mean_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign mean_out   = mean_out_q;
    assign mean_valid = mean_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
